// File: rtl/edge_trigger.sv
// Level-crossing trigger with symmetric hysteresis, holdoff, auto-trigger on
// timeout, and period measurement between consecutive real triggers.
module edge_trigger #(
  parameter int DATA_W       = 12,
  parameter int HYST         = 8,
  parameter int HOLDOFF      = 16,
  parameter int AUTO_TIMEOUT = 100000,
  parameter int PERIOD_W     = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]   level,
  input  logic                edge_sel,
  input  logic                auto_en,
  input  logic                run,
  output logic                armed,
  output logic                trig,
  output logic                trig_auto,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                period_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam logic [1:0] S_AFTER_FIRE = (HOLDOFF == 0) ? S_PRIME : S_HOLD;

  localparam int TO_W = (AUTO_TIMEOUT < 1) ? 1 : $clog2(AUTO_TIMEOUT + 1);
  localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [TO_W-1:0]     TO_LIMIT = TO_W'(AUTO_TIMEOUT);
  localparam logic [HO_W-1:0]     HO_LIMIT = HO_W'(HOLDOFF);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [DATA_W:0]     HYST_X   = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0]     FULL_X   = {1'b0, {DATA_W{1'b1}}};

  logic [1:0]          r_state;
  logic                r_edge;
  logic [TO_W-1:0]     r_to_cnt;
  logic [HO_W-1:0]     r_ho_cnt;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_chain;
  logic                r_armed;
  logic                r_trig;
  logic                r_trig_auto;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic                r_ovf;

  logic [DATA_W:0]     w_level_x;
  logic [DATA_W:0]     w_hi_x;
  logic [DATA_W-1:0]   w_lo;
  logic [DATA_W-1:0]   w_hi;
  logic                w_arm_hit;
  logic                w_cross_hit;
  logic                w_armed_state;
  logic                w_real_fire;
  logic                w_auto_fire;
  logic                w_fire;
  logic [TO_W-1:0]     w_to_inc;
  logic [HO_W-1:0]     w_ho_inc;
  logic                w_ho_last;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic [1:0]          w_state_nxt;

  // Saturating thresholds track the live level every cycle.
  assign w_level_x = {1'b0, level};
  assign w_hi_x    = w_level_x + HYST_X;
  assign w_hi      = (w_hi_x > FULL_X) ? FULL_X[DATA_W-1:0] : w_hi_x[DATA_W-1:0];
  assign w_lo      = (w_level_x < HYST_X) ? '0 : level - HYST_X[DATA_W-1:0];

  assign w_arm_hit   = r_edge ? (data_in > w_hi)   : (data_in < w_lo);
  assign w_cross_hit = r_edge ? (data_in <= level) : (data_in >= level);

  assign w_armed_state = (r_state == S_PRIME) || (r_state == S_WAIT);
  assign w_to_inc      = (r_to_cnt >= TO_LIMIT) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_ho_inc      = r_ho_cnt + 1'b1;
  assign w_ho_last     = (w_ho_inc >= HO_LIMIT);
  assign w_cnt_inc     = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

  // A real crossing on the timeout sample suppresses the auto trigger.
  assign w_real_fire = sample_valid && (r_state == S_WAIT) && w_cross_hit;
  assign w_auto_fire = sample_valid && w_armed_state && auto_en &&
                       (w_to_inc >= TO_LIMIT) && !w_real_fire;
  assign w_fire      = w_real_fire || w_auto_fire;

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    w_state_nxt = r_state;
    if (!run) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_PRIME;
        S_PRIME: begin
          if (w_fire)                        w_state_nxt = S_AFTER_FIRE;
          else if (sample_valid && w_arm_hit) w_state_nxt = S_WAIT;
        end
        S_WAIT:  if (w_fire) w_state_nxt = S_AFTER_FIRE;
        S_HOLD:  if (sample_valid && w_ho_last) w_state_nxt = S_PRIME;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_edge         <= 1'b0;
      r_to_cnt       <= '0;
      r_ho_cnt       <= '0;
      r_cnt          <= '0;
      r_chain        <= 1'b0;
      r_armed        <= 1'b0;
      r_trig         <= 1'b0;
      r_trig_auto    <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == S_PRIME) || (w_state_nxt == S_WAIT);
      if (!run) begin
        r_trig         <= 1'b0;
        r_trig_auto    <= 1'b0;
        r_period_valid <= 1'b0;
        r_to_cnt       <= '0;
        r_ho_cnt       <= '0;
        r_cnt          <= '0;
        r_chain        <= 1'b0;
        r_ovf          <= 1'b0;
      end else begin
        r_trig         <= w_fire;
        r_trig_auto    <= w_auto_fire;
        r_period_valid <= w_real_fire && r_chain;
        if (w_real_fire && r_chain) r_period <= w_cnt_inc;

        if (r_state == S_IDLE) begin
          r_edge   <= edge_sel;
          r_to_cnt <= '0;
          r_ho_cnt <= '0;
          r_cnt    <= '0;
          r_chain  <= 1'b0;
        end else if (sample_valid) begin
          if (w_fire) begin
            r_to_cnt <= '0;
            r_ho_cnt <= '0;
            r_cnt    <= '0;
            r_chain  <= w_real_fire;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_armed_state)     r_to_cnt <= w_to_inc;
            if (r_state == S_HOLD) r_ho_cnt <= w_ho_last ? '0 : w_ho_inc;
          end
          if (w_cnt_inc == CNT_MAX) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign armed        = r_armed;
  assign trig         = r_trig;
  assign trig_auto    = r_trig_auto;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign period_ovf   = r_ovf;

endmodule

// File: tb/tb_edge_trigger.sv
// Directed bench for edge_trigger: reset, rising/falling timing, hysteresis,
// period/holdoff, auto mode with timeout tie-break, and run abort.
module tb_edge_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [11:0] data_in;
  logic [11:0] level;
  logic        edge_sel;
  logic        auto_en;
  logic        run;
  logic        armed;
  logic        trig;
  logic        trig_auto;
  logic [23:0] period;
  logic        period_valid;
  logic        period_ovf;

  int n_vec = 0;
  int n_err = 0;
  int gap_trigs = 0;

  edge_trigger #(
    .DATA_W(12), .HYST(8), .HOLDOFF(16), .AUTO_TIMEOUT(100), .PERIOD_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .data_in(data_in),
    .level(level), .edge_sel(edge_sel), .auto_en(auto_en), .run(run),
    .armed(armed), .trig(trig), .trig_auto(trig_auto), .period(period),
    .period_valid(period_valid), .period_ovf(period_ovf)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [11:0] d);
    @(negedge clk);
    sample_valid = v;
    data_in      = d;
    @(posedge clk);
    #1;
  endtask

  // One strobe followed by one idle cycle; outputs captured after the strobe.
  task automatic sample(input logic [11:0] d, output logic t, output logic ta, output logic pv);
    drive(1'b1, d);
    t  = trig;
    ta = trig_auto;
    pv = period_valid;
    drive(1'b0, d);
    if (trig !== 1'b0 || trig_auto !== 1'b0 || period_valid !== 1'b0) gap_trigs++;
  endtask

  task automatic restart();
    run = 1'b0;
    drive(1'b0, 12'd0);
    run = 1'b1;
    drive(1'b0, 12'd0);
  endtask

  task automatic test_reset();
    logic t, ta, pv;
    rst_n = 1'b0; run = 1'b0; edge_sel = 1'b0; auto_en = 1'b0; level = 12'd2048;
    for (int i = 0; i < 3; i++) drive(1'b1, (i % 2 == 0) ? 12'd2030 : 12'd2050);
    n_vec++;
    if ({armed, trig, trig_auto, period_valid, period_ovf, period} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got armed=%b trig=%b auto=%b pv=%b ovf=%b period=%0d, want all 0",
               armed, trig, trig_auto, period_valid, period_ovf, period);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample((i % 2 == 0) ? 12'd2030 : 12'd2050, t, ta, pv);
      n_vec++;
      if ({armed, t, ta, pv} !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_run0 #%0d: got armed=%b trig=%b auto=%b pv=%b, want 0000", i, armed, t, ta, pv);
      end
    end
  endtask

  task automatic test_rising();
    logic t, ta, pv;
    logic [11:0] seq [4] = '{12'd2045, 12'd2050, 12'd2030, 12'd2045};
    edge_sel = 1'b0; auto_en = 1'b0; level = 12'd2048;
    restart();
    n_vec++;
    if (armed !== 1'b1) begin n_err++; $display("FAIL rise_armed: got %b want 1", armed); end
    foreach (seq[i]) begin
      sample(seq[i], t, ta, pv);
      n_vec++;
      if (t !== 1'b0) begin n_err++; $display("FAIL rise_early #%0d (%0d): got trig=%b want 0", i, seq[i], t); end
    end
    drive(1'b1, 12'd2050);
    n_vec++;
    if ({trig, trig_auto, period_valid, armed} !== 4'b1000) begin
      n_err++;
      $display("FAIL rise_fire: got trig=%b auto=%b pv=%b armed=%b, want 1 0 0 0",
               trig, trig_auto, period_valid, armed);
    end
    drive(1'b0, 12'd2050);
    n_vec++;
    if (trig !== 1'b0) begin n_err++; $display("FAIL rise_pulse_width: got trig=%b want 0", trig); end
  endtask

  task automatic test_hysteresis();
    logic t, ta, pv;
    int   cnt = 0;
    edge_sel = 1'b0; level = 12'd2048;
    restart();
    for (int i = 0; i < 10; i++) begin
      sample(12'd2044, t, ta, pv); cnt += int'(t);
      sample(12'd2052, t, ta, pv); cnt += int'(t);
    end
    n_vec++;
    if (cnt != 0) begin n_err++; $display("FAIL hyst_noise: got %0d triggers want 0", cnt); end
    sample(12'd2039, t, ta, pv);
    n_vec++;
    if (t !== 1'b0) begin n_err++; $display("FAIL hyst_dip: got trig=%b want 0", t); end
    sample(12'd2048, t, ta, pv);
    n_vec++;
    if ({t, pv} !== 2'b10) begin n_err++; $display("FAIL hyst_fire: got trig=%b pv=%b want 1 0", t, pv); end
  endtask

  task automatic test_period();
    logic t, ta, pv;
    logic exp_t, exp_pv;
    int   g0 = gap_trigs;
    edge_sel = 1'b0; auto_en = 1'b0; level = 12'd2048;
    restart();
    for (int i = 0; i < 250; i++) begin
      sample(((i % 50) < 25) ? 12'd1000 : 12'd3000, t, ta, pv);
      exp_t  = ((i % 50) == 25);
      exp_pv = exp_t && (i > 25);
      n_vec++;
      if ({t, ta, pv} !== {exp_t, 1'b0, exp_pv}) begin
        n_err++;
        $display("FAIL period_seq #%0d: got trig=%b auto=%b pv=%b want %b 0 %b", i, t, ta, pv, exp_t, exp_pv);
      end
      if (exp_pv) begin
        n_vec++;
        if (period !== 24'd50) begin n_err++; $display("FAIL period_value #%0d: got %0d want 50", i, period); end
      end
    end
    n_vec++;
    if (gap_trigs != g0) begin n_err++; $display("FAIL period_gap: got %0d off-strobe pulses want 0", gap_trigs - g0); end
  endtask

  task automatic test_auto();
    logic t, ta, pv;
    logic exp_f;
    int   cnt = 0;
    edge_sel = 1'b0; auto_en = 1'b1; level = 12'd2048;
    restart();
    for (int i = 0; i < 340; i++) begin
      sample(12'd2048, t, ta, pv);
      exp_f = (i == 99) || (i == 215) || (i == 331);
      n_vec++;
      if ({t, ta, pv} !== {exp_f, exp_f, 1'b0}) begin
        n_err++;
        $display("FAIL auto_seq #%0d: got trig=%b auto=%b pv=%b want %b %b 0", i, t, ta, pv, exp_f, exp_f);
      end
    end
    // Timeout and a real crossing on the same (100th) strobe.
    restart();
    for (int i = 0; i < 98; i++) begin
      sample(12'd2048, t, ta, pv);
      cnt += int'(t);
    end
    sample(12'd2030, t, ta, pv);
    cnt += int'(t);
    n_vec++;
    if (cnt != 0) begin n_err++; $display("FAIL auto_tie_pre: got %0d triggers want 0", cnt); end
    sample(12'd2050, t, ta, pv);
    n_vec++;
    if ({t, ta, pv} !== 3'b100) begin n_err++; $display("FAIL auto_tie: got trig=%b auto=%b pv=%b want 1 0 0", t, ta, pv); end
    auto_en = 1'b0;
    restart();
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      sample(12'd2048, t, ta, pv);
      cnt += int'(t);
    end
    n_vec++;
    if (cnt != 0) begin n_err++; $display("FAIL auto_off: got %0d triggers want 0", cnt); end
  endtask

  task automatic test_falling_abort();
    logic t, ta, pv;
    logic [11:0] ramp [7] = '{12'd2100, 12'd2090, 12'd2080, 12'd2070, 12'd2060, 12'd2050, 12'd2040};
    auto_en = 1'b0; level = 12'd2048;
    edge_sel = 1'b1;
    restart();
    edge_sel = 1'b0;
    foreach (ramp[i]) begin
      sample(ramp[i], t, ta, pv);
      n_vec++;
      if ({t, pv} !== {(i == 6), 1'b0}) begin
        n_err++;
        $display("FAIL fall_ramp #%0d (%0d): got trig=%b pv=%b want %b 0", i, ramp[i], t, pv, (i == 6));
      end
    end
    for (int i = 0; i < 3; i++) sample(12'd2100, t, ta, pv);
    n_vec++;
    if (armed !== 1'b0) begin n_err++; $display("FAIL fall_holdoff_armed: got %b want 0", armed); end
    run = 1'b0;
    drive(1'b1, 12'd2040);
    n_vec++;
    if ({armed, trig, period_ovf} !== 3'b000 || period !== 24'd50) begin
      n_err++;
      $display("FAIL abort: got armed=%b trig=%b ovf=%b period=%0d want 0 0 0 50", armed, trig, period_ovf, period);
    end
    drive(1'b0, 12'd2040);
    edge_sel = 1'b1;
    run = 1'b1;
    drive(1'b0, 12'd2040);
    n_vec++;
    if (armed !== 1'b1) begin n_err++; $display("FAIL rerun_armed: got %b want 1", armed); end
    sample(12'd2040, t, ta, pv);
    n_vec++;
    if (t !== 1'b0) begin n_err++; $display("FAIL rerun_unprimed: got trig=%b want 0", t); end
    sample(12'd2100, t, ta, pv);
    sample(12'd2040, t, ta, pv);
    n_vec++;
    if ({t, ta, pv} !== 3'b100) begin n_err++; $display("FAIL rerun_first: got trig=%b auto=%b pv=%b want 1 0 0", t, ta, pv); end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; sample_valid = 1'b0; data_in = '0;
    level = 12'd2048; edge_sel = 1'b0; auto_en = 1'b0;
    test_reset();
    test_rising();
    test_hysteresis();
    test_period();
    test_auto();
    test_falling_abort();
    n_vec++;
    if (gap_trigs != 0) begin n_err++; $display("FAIL off_strobe_pulses: got %0d want 0", gap_trigs); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
